// File: rtl/pmem_acc_ctrl_if.sv
// Bus bundle between the PMEM accumulation controller and its surroundings:
// job control, OFIFO pop, PMEM port, accumulate/ReLU base and final-row flag.
interface pmem_acc_ctrl_if #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 4,
  parameter int pass_bw = 4
);
  logic                     start;
  logic [addr_bw-1:0]       num_addr;
  logic [pass_bw-1:0]       num_pass;
  logic                     ofifo_valid;
  logic                     ofifo_rd;
  logic [psum_bw*col-1:0]   pmem_q;
  logic                     pmem_cen;
  logic                     pmem_wen;
  logic [addr_bw-1:0]       pmem_addr;
  logic [psum_bw*col-1:0]   base_out;
  logic                     acc;
  logic                     sfp_valid;
  logic [addr_bw-1:0]       sfp_addr;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, num_addr, num_pass, ofifo_valid, pmem_q,
    output ofifo_rd, pmem_cen, pmem_wen, pmem_addr, base_out,
           acc, sfp_valid, sfp_addr, busy, done
  );

  modport slave (
    output start, num_addr, num_pass, ofifo_valid, pmem_q,
    input  ofifo_rd, pmem_cen, pmem_wen, pmem_addr, base_out,
           acc, sfp_valid, sfp_addr, busy, done
  );
endinterface

// File: rtl/pmem_acc_ctrl.sv
// Read-modify-write sequencer for the partial-sum memory: READ, ALIGN, WRITE
// per row, N rows per pass, P passes, final pass drops acc and flags rows.
module pmem_acc_ctrl #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 4,
  parameter int pass_bw = 4
) (
  input logic             clk,
  input logic             reset,
  pmem_acc_ctrl_if.master bus
);

  localparam int data_w = psum_bw * col;
  localparam logic [data_w-1:0]  data_zero = {data_w{1'b0}};
  localparam logic [addr_bw-1:0] addr_zero = {addr_bw{1'b0}};
  localparam logic [addr_bw-1:0] addr_one  = {{(addr_bw-1){1'b0}}, 1'b1};
  localparam logic [pass_bw-1:0] pass_zero = {pass_bw{1'b0}};
  localparam logic [pass_bw-1:0] pass_one  = {{(pass_bw-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ALIGN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_r, state_n_s;
  logic [addr_bw-1:0] a_r, a_n_s;
  logic [pass_bw-1:0] p_r, p_n_s;
  logic               last_row_s;
  logic               last_pass_s;
  logic               first_pass_s;

  // Counters only ever range 0..N-1 / 0..P-1, so equality marks the last one.
  assign last_row_s   = (a_r == (bus.num_addr - addr_one));
  assign last_pass_s  = (p_r == (bus.num_pass - pass_one));
  assign first_pass_s = (p_r == pass_zero);

  // State and row/pass counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      a_r     <= addr_zero;
      p_r     <= pass_zero;
    end else begin
      state_r <= state_n_s;
      a_r     <= a_n_s;
      p_r     <= p_n_s;
    end
  end

  // Next-state, counter advance and output decode.
  always_comb begin
    state_n_s     = state_r;
    a_n_s         = a_r;
    p_n_s         = p_r;
    bus.ofifo_rd  = 1'b0;
    bus.pmem_cen  = 1'b1;
    bus.pmem_wen  = 1'b1;
    bus.pmem_addr = a_r;
    bus.base_out  = first_pass_s ? data_zero : bus.pmem_q;
    bus.acc       = 1'b1;
    bus.sfp_valid = 1'b0;
    bus.sfp_addr  = addr_zero;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (state_r)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          // An empty job still reports completion, but touches nothing.
          if ((bus.num_addr != addr_zero) && (bus.num_pass != pass_zero)) begin
            state_n_s = S_READ;
          end else begin
            state_n_s = S_DONE;
          end
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_READ: begin
        if (bus.ofifo_valid) begin
          bus.ofifo_rd = 1'b1;
          bus.pmem_cen = 1'b0;
          state_n_s    = S_ALIGN;
        end else begin
          state_n_s = S_READ;
        end
      end
      S_ALIGN: begin
        if (last_pass_s) begin
          bus.acc = 1'b0;
        end else begin
          bus.acc = 1'b1;
        end
        state_n_s = S_WRITE;
      end
      S_WRITE: begin
        bus.pmem_cen = 1'b0;
        bus.pmem_wen = 1'b0;
        if (last_pass_s) begin
          bus.sfp_valid = 1'b1;
          bus.sfp_addr  = a_r;
        end else begin
          bus.sfp_valid = 1'b0;
        end
        if (!last_row_s) begin
          a_n_s     = a_r + addr_one;
          state_n_s = S_READ;
        end else if (!last_pass_s) begin
          a_n_s     = addr_zero;
          p_n_s     = p_r + pass_one;
          state_n_s = S_READ;
        end else begin
          state_n_s = S_DONE;
        end
      end
      S_DONE: begin
        bus.done  = 1'b1;
        a_n_s     = addr_zero;
        p_n_s     = pass_zero;
        state_n_s = S_IDLE;
      end
      default: begin
        bus.busy  = 1'b0;
        a_n_s     = addr_zero;
        p_n_s     = pass_zero;
        state_n_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pmem_acc_ctrl.sv
// Scoreboard bench for pmem_acc_ctrl: job timelines and row sums predicted
// from the row/pass rules, compared by a monitor against observed bus activity.
module tb_pmem_acc_ctrl;
  localparam int PB = 16, COL = 8, AB = 4, PSB = 4, DW = PB * COL;

  typedef struct { int cyc; int addr; } rd_t;
  typedef struct { int cyc; int addr; logic [DW-1:0] data; bit sfp; } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pmem_acc_ctrl_if #(.psum_bw(PB), .col(COL), .addr_bw(AB), .pass_bw(PSB)) bus();
  pmem_acc_ctrl #(.psum_bw(PB), .col(COL), .addr_bw(AB), .pass_bw(PSB)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit vpat [0:65535];
  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] ofifo_dout = '0;
  logic [DW-1:0] sum_r = '0;
  logic [DW-1:0] ofq [$];
  logic          preload_req = 1'b0;
  logic [DW-1:0] preload_val = '0;
  rd_t rdq [$];
  wr_t wrq [$];
  int  accq [$];
  int  doneq [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PB +: PB] = x[i*PB +: PB] + y[i*PB +: PB];
    return r;
  endfunction

  // Environment: OFIFO with 1-cycle data, single-port PMEM, accumulate unit.
  always @(posedge clk) begin
    sum_r <= lane_add(ofifo_dout, bus.base_out);
    if (bus.ofifo_rd === 1'b1) ofifo_dout <= (ofq.size() > 0) ? ofq.pop_front() : '0;
    if (preload_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= preload_val;
    end else if (bus.pmem_cen === 1'b0) begin
      if (bus.pmem_wen === 1'b0) mem[bus.pmem_addr] <= sum_r;
      else bus.pmem_q <= mem[bus.pmem_addr];
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with nothing expected at cycle %0d", name, cyc);
  endtask

  task automatic monitor_step();
    rd_t r;
    wr_t w;
    int  e;
    if (bus.pmem_cen === 1'b0 && bus.pmem_wen === 1'b1) begin
      if (rdq.size() == 0) unexpected("pmem_read");
      else begin
        r = rdq.pop_front();
        check("rd_cycle", cyc, r.cyc);
        check("rd_addr", bus.pmem_addr, r.addr);
        check("rd_ofifo_rd", bus.ofifo_rd, 1);
      end
    end else if (bus.ofifo_rd !== 1'b0) begin
      unexpected("ofifo_rd");
    end
    if (bus.pmem_cen === 1'b0 && bus.pmem_wen === 1'b0) begin
      if (wrq.size() == 0) unexpected("pmem_write");
      else begin
        w = wrq.pop_front();
        check("wr_cycle", cyc, w.cyc);
        check("wr_addr", bus.pmem_addr, w.addr);
        check("wr_data", sum_r, w.data);
        check("wr_sfp_valid", bus.sfp_valid, w.sfp);
        if (w.sfp) check("wr_sfp_addr", bus.sfp_addr, w.addr);
      end
    end else if (bus.sfp_valid !== 1'b0) begin
      unexpected("sfp_valid");
    end
    if (bus.acc !== 1'b1) begin
      if (accq.size() == 0) unexpected("acc_low");
      else begin
        e = accq.pop_front();
        check("acc_cycle", cyc, e);
      end
    end
    if (bus.done !== 1'b0) begin
      if (doneq.size() == 0) unexpected("done");
      else begin
        e = doneq.pop_front();
        check("done_cycle", cyc, e);
        check("done_busy", bus.busy, 1);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) monitor_step();
  end

  // OFIFO valid follows the per-cycle pattern prepared by each job.
  initial begin
    bus.ofifo_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.ofifo_valid = vpat[cyc];
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ofifo_rd"}, bus.ofifo_rd, 0);
    check({tag, "_pmem_cen"}, bus.pmem_cen, 1);
    check({tag, "_pmem_wen"}, bus.pmem_wen, 1);
    check({tag, "_pmem_addr"}, bus.pmem_addr, 0);
    check({tag, "_acc"}, bus.acc, 1);
    check({tag, "_sfp_valid"}, bus.sfp_valid, 0);
    check({tag, "_sfp_addr"}, bus.sfp_addr, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  // vmode 1: PMEM preloaded with 5s and OFIFO vectors of all 1s.
  task automatic run_job(input int n, input int p, input int vmode, input int stall5,
                         input int rndv, input int pulse_at, input int abort_k);
    int c, t, k, done_t, abort_cyc, end_cyc;
    bit stop;
    logic [DW-1:0] vecs [$];
    logic [DW-1:0] v, row;
    int rowsum [0:15][0:COL-1];
    if (vmode == 1) begin
      preload_val = {COL{16'd5}};
      preload_req = 1'b1;
      @(posedge clk);
      #1;
      preload_req = 1'b0;
    end
    c = cyc;
    for (int i = c + 1; i < c + 3000; i++) vpat[i] = (rndv != 0) ? ($urandom_range(3, 0) != 0) : 1'b1;
    if (stall5 != 0) for (int i = c + 1; i <= c + 5; i++) vpat[i] = 1'b0;
    for (int i = 0; i < n * p; i++) begin
      v = (vmode == 1) ? {COL{16'd1}} : {$urandom, $urandom, $urandom, $urandom};
      vecs.push_back(v);
      ofq.push_back(v);
    end
    // Reference timeline: each row reads when valid, aligns, then writes.
    t = c + 1; k = 0; abort_cyc = -1; stop = 1'b0;
    if (n == 0 || p == 0) done_t = c + 1;
    else begin
      for (int pp = 0; pp < p && !stop; pp++) begin
        for (int aa = 0; aa < n && !stop; aa++) begin
          while (vpat[t] == 1'b0) t++;
          rdq.push_back('{cyc: t, addr: aa});
          if (pp == p - 1) accq.push_back(t + 1);
          v = vecs[k];
          for (int l = 0; l < COL; l++) begin
            rowsum[aa][l] = ((pp == 0 ? 0 : rowsum[aa][l]) + int'(v[l*PB +: PB])) % 65536;
            row[l*PB +: PB] = 16'(rowsum[aa][l]);
          end
          wrq.push_back('{cyc: t + 2, addr: aa, data: row, sfp: (pp == p - 1)});
          if (k == abort_k) begin
            abort_cyc = t + 2;
            stop = 1'b1;
          end
          k++;
          t += 3;
        end
      end
      done_t = t;
    end
    if (abort_cyc < 0) doneq.push_back(done_t);
    bus.num_addr = AB'(n);
    bus.num_pass = PSB'(p);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    end_cyc = (abort_cyc >= 0) ? abort_cyc + 2 : done_t + 2;
    while (cyc < end_cyc) begin
      bus.start = (pulse_at > 0) && (cyc == c + pulse_at);
      if (cyc == abort_cyc) reset = 1'b0;
      @(posedge clk);
      #1;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        reset = 1'b1;
        ofq.delete();
        check_reset_outputs("abort");
      end
    end
    bus.start = 1'b0;
    check("queues_drained", rdq.size() + wrq.size() + accq.size() + doneq.size(), 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) vpat[i] = 1'b1;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.num_addr = '0;
    bus.num_pass = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_job(2, 1, 0, 0, 0, 0, -1);
    run_job(4, 3, 1, 0, 0, 0, -1);
    for (int a = 0; a < 4; a++) check("final_row_value", mem[a], {COL{16'd3}});
    run_job(3, 2, 0, 1, 0, 0, -1);
    run_job(4, 3, 0, 0, 0, 0, 6);
    run_job(2, 2, 0, 0, 0, 0, -1);
    run_job(3, 0, 0, 0, 0, 0, -1);
    run_job(0, 2, 0, 0, 0, 0, -1);
    run_job(2, 2, 0, 0, 0, 5, -1);
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(8, 1), $urandom_range(6, 1), 0, 0, 1, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
